// File: rtl/vic_regfile_dbuf_if.sv
// vic_regfile_dbuf_if: CPU/video bus bundle for the double-buffered VIC register file.
//   Inputs to the register file:  i_VIC_regaddr, i_VIC_data, i_VIC_we, i_VIC_re,
//                                 i_commit, i_status
//   Outputs from the register file: o_VIC_data, o_rvalid, o_err, o_dirty,
//                                 o_commit_done, buffer
//   master: the CPU / frame-timing side driving the register file.
//   slave:  the register file itself.
interface vic_regfile_dbuf_if #(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
);
    logic [ADDR_W-1:0]          i_VIC_regaddr;
    logic [DATA_W-1:0]          i_VIC_data;
    logic                       i_VIC_we;
    logic                       i_VIC_re;
    logic [DATA_W-1:0]          o_VIC_data;
    logic                       o_rvalid;
    logic                       o_err;
    logic                       i_commit;
    logic [NUM_REGS*DATA_W-1:0] i_status;
    logic                       o_dirty;
    logic                       o_commit_done;
    logic [NUM_REGS*DATA_W-1:0] buffer;

    modport master (
        output i_VIC_regaddr, i_VIC_data, i_VIC_we, i_VIC_re, i_commit, i_status,
        input  o_VIC_data, o_rvalid, o_err, o_dirty, o_commit_done, buffer
    );

    modport slave (
        input  i_VIC_regaddr, i_VIC_data, i_VIC_we, i_VIC_re, i_commit, i_status,
        output o_VIC_data, o_rvalid, o_err, o_dirty, o_commit_done, buffer
    );
endinterface

// File: rtl/vic_regfile_dbuf.sv
// vic_regfile_dbuf: double-buffered VIC register file.
//   The CPU writes/reads a shadow array; i_commit copies the shadow into the
//   active array in one cycle, and the active array drives the flattened
//   buffer to the video pipeline. Registers flagged in RO_MASK are status
//   registers loaded every cycle from i_status into both arrays.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   bus      vic_regfile_dbuf_if.slave (address/data/we/re, read data with
//            rvalid/err pulses, commit strobe, status inputs, dirty flag,
//            commit_done pulse, flattened active buffer)
module vic_regfile_dbuf #(
    parameter int unsigned         DATA_W    = 4,
    parameter int unsigned         ADDR_W    = 5,
    parameter int unsigned         NUM_REGS  = 32,
    parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
    parameter bit                  IMMEDIATE = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    vic_regfile_dbuf_if.slave    bus
);
    typedef logic [DATA_W-1:0] reg_t;

    reg_t shadow_q [NUM_REGS];
    reg_t shadow_d [NUM_REGS];
    reg_t active_q [NUM_REGS];
    reg_t active_d [NUM_REGS];

    reg_t rdata_q, rdata_d;
    logic rvalid_q, rvalid_d;
    logic err_q, err_d;
    logic dirty_q, dirty_d;
    logic commit_done_q, commit_done_d;

    logic [NUM_REGS-1:0]        sel;
    logic                       in_range;
    logic                       ro_hit;
    logic                       wr_ok;
    reg_t                       rd_val;
    logic [NUM_REGS*DATA_W-1:0] buffer_w;

    // One-hot address decode; an address >= NUM_REGS selects nothing.
    always_comb begin
        sel    = '0;
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            sel[i] = (bus.i_VIC_regaddr == ADDR_W'(i));
            if (sel[i]) begin
                rd_val = shadow_q[i];
            end
        end
        in_range = |sel;
        ro_hit   = |(sel & RO_MASK);
        wr_ok    = bus.i_VIC_we && in_range && !ro_hit;
    end

    // Commit copies the post-write shadow, so a write in the commit cycle is
    // included. Status registers bypass both the CPU write and the commit.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = active_q[i];
            if (RO_MASK[i]) begin
                shadow_d[i] = bus.i_status[i*DATA_W +: DATA_W];
                active_d[i] = bus.i_status[i*DATA_W +: DATA_W];
            end else begin
                if (wr_ok && sel[i]) begin
                    shadow_d[i] = bus.i_VIC_data;
                end
                if (bus.i_commit && !IMMEDIATE) begin
                    active_d[i] = shadow_d[i];
                end
            end
        end
    end

    // Reads sample shadow_q, which gives read-before-write on a same-address
    // we+re cycle.
    always_comb begin
        rdata_d       = rdata_q;
        rvalid_d      = bus.i_VIC_re;
        err_d         = (bus.i_VIC_we && (!in_range || ro_hit)) ||
                        (bus.i_VIC_re && !in_range);
        commit_done_d = bus.i_commit;
        if (bus.i_VIC_re) begin
            rdata_d = rd_val;
        end
        dirty_d = dirty_q;
        if (IMMEDIATE || bus.i_commit) begin
            dirty_d = 1'b0;
        end else if (wr_ok) begin
            dirty_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
            err_q         <= 1'b0;
            dirty_q       <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
            err_q         <= err_d;
            dirty_q       <= dirty_d;
            commit_done_q <= commit_done_d;
        end
    end

    always_comb begin
        buffer_w = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            buffer_w[i*DATA_W +: DATA_W] = IMMEDIATE ? shadow_q[i] : active_q[i];
        end
    end

    assign bus.buffer        = buffer_w;
    assign bus.o_VIC_data    = rdata_q;
    assign bus.o_rvalid      = rvalid_q;
    assign bus.o_err         = err_q;
    assign bus.o_dirty       = dirty_q;
    assign bus.o_commit_done = commit_done_q;

endmodule

// File: tb/tb_vic_regfile_dbuf.sv
// tb_vic_regfile_dbuf: directed, table-driven bench for vic_regfile_dbuf.
//   Two instances share stimulus: a double-buffered one and an IMMEDIATE one,
//   both with NUM_REGS = 24, ADDR_W = 5, register 1 read-only.
module tb_vic_regfile_dbuf;
    localparam int unsigned DW = 4;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 24;
    localparam logic [NR-1:0] ROM = 24'h000002;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vic_regfile_dbuf_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) bm ();
    vic_regfile_dbuf_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) bi ();

    vic_regfile_dbuf #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR),
                       .RO_MASK(ROM), .IMMEDIATE(1'b0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bm));

    vic_regfile_dbuf #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR),
                       .RO_MASK(ROM), .IMMEDIATE(1'b1)) dut_imm (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bi));

    assign bi.i_VIC_regaddr = bm.i_VIC_regaddr;
    assign bi.i_VIC_data    = bm.i_VIC_data;
    assign bi.i_VIC_we      = bm.i_VIC_we;
    assign bi.i_VIC_re      = bm.i_VIC_re;
    assign bi.i_commit      = bm.i_commit;
    assign bi.i_status      = bm.i_status;

    typedef struct {
        logic          we, re, commit;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] st1;
        int            chk;
        logic [DW-1:0] e_rdata;
        logic          e_rvalid, e_err, e_dirty, e_cd;
        logic [DW-1:0] e_buf, e_ibuf;
    } vec_t;

    vec_t vecs [20];
    int   errors = 0;
    int   checks = 0;
    logic [DW-1:0] model [NR];
    logic [NR*DW-1:0] exp_flat;

    function automatic vec_t mk(logic we, logic re, logic cm, int addr, int wd, int st,
                                int chk, int erd, logic erv, logic eer, logic edt,
                                logic ecd, int eb, int eib);
        vec_t v;
        v.we = we; v.re = re; v.commit = cm;
        v.addr = AW'(addr); v.wdata = DW'(wd); v.st1 = DW'(st);
        v.chk = chk; v.e_rdata = DW'(erd); v.e_rvalid = erv; v.e_err = eer;
        v.e_dirty = edt; v.e_cd = ecd; v.e_buf = DW'(eb); v.e_ibuf = DW'(eib);
        return v;
    endfunction

    task automatic check(input string name, input logic [NR*DW-1:0] act,
                         input logic [NR*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_status1(input logic [DW-1:0] v);
        logic [NR*DW-1:0] s;
        s = {NR{4'hF}};
        s[1*DW +: DW] = v;
        bm.i_status = s;
    endtask

    task automatic idle_inputs();
        bm.i_VIC_we = 1'b0; bm.i_VIC_re = 1'b0; bm.i_commit = 1'b0;
        bm.i_VIC_regaddr = '0; bm.i_VIC_data = '0;
    endtask

    initial begin
        //            we re cm addr wd st  chk rdata rv er dt cd buf ibuf
        vecs[0]  = mk(0, 0, 0,  0,  0, 12,  1,  0,  0, 0, 0, 0, 12, 12);
        vecs[1]  = mk(1, 0, 0,  3, 10, 12,  3,  0,  0, 0, 1, 0,  0, 10);
        vecs[2]  = mk(0, 1, 0,  3,  0, 12,  3, 10,  1, 0, 1, 0,  0, 10);
        vecs[3]  = mk(0, 0, 1,  0,  0, 12,  3, 10,  0, 0, 0, 1, 10, 10);
        vecs[4]  = mk(0, 0, 0,  0,  0, 12,  3, 10,  0, 0, 0, 0, 10, 10);
        vecs[5]  = mk(1, 0, 1,  5,  7, 12,  5, 10,  0, 0, 0, 1,  7,  7);
        vecs[6]  = mk(1, 1, 0,  5,  2, 12,  5,  7,  1, 0, 1, 0,  7,  2);
        vecs[7]  = mk(0, 1, 0,  5,  0, 12,  5,  2,  1, 0, 1, 0,  7,  2);
        vecs[8]  = mk(1, 0, 0,  1,  3, 12,  1,  2,  0, 1, 1, 0, 12, 12);
        vecs[9]  = mk(0, 1, 0,  1,  0, 12,  1, 12,  1, 0, 1, 0, 12, 12);
        vecs[10] = mk(0, 0, 0,  0,  0,  5,  1, 12,  0, 0, 1, 0,  5,  5);
        vecs[11] = mk(1, 0, 0, 30, 15,  5,  5, 12,  0, 1, 1, 0,  7,  2);
        vecs[12] = mk(0, 1, 0, 30,  0,  5,  5,  0,  1, 1, 1, 0,  7,  2);
        vecs[13] = mk(0, 1, 0, 14,  0,  5, 14,  0,  1, 0, 1, 0,  0,  0);
        vecs[14] = mk(0, 0, 1,  0,  0,  5,  5,  0,  0, 0, 0, 1,  2,  2);
        vecs[15] = mk(0, 0, 1,  0,  0,  5,  3,  0,  0, 0, 0, 1, 10, 10);
        vecs[16] = mk(1, 0, 0, 23,  9,  5, 23,  0,  0, 0, 1, 0,  0,  9);
        vecs[17] = mk(0, 1, 0, 23,  0,  5, 23,  9,  1, 0, 1, 0,  0,  9);
        vecs[18] = mk(1, 0, 0, 24,  1,  5, 23,  9,  0, 1, 1, 0,  0,  9);
        vecs[19] = mk(0, 1, 0, 24,  0,  5, 23,  0,  1, 1, 1, 0,  0,  9);

        idle_inputs();
        set_status1(4'hC);
        repeat (3) @(posedge clk);
        #1;
        check("reset rdata",  NR*DW'(bm.o_VIC_data), '0);
        check("reset rvalid", NR*DW'(bm.o_rvalid), '0);
        check("reset err",    NR*DW'(bm.o_err), '0);
        check("reset dirty",  NR*DW'(bm.o_dirty), '0);
        check("reset cdone",  NR*DW'(bm.o_commit_done), '0);
        check("reset buffer", bm.buffer, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bm.i_VIC_we = vecs[i].we; bm.i_VIC_re = vecs[i].re;
            bm.i_commit = vecs[i].commit; bm.i_VIC_regaddr = vecs[i].addr;
            bm.i_VIC_data = vecs[i].wdata;
            set_status1(vecs[i].st1);
            @(posedge clk);
            #1;
            check($sformatf("v%0d rdata", i),  NR*DW'(bm.o_VIC_data), NR*DW'(vecs[i].e_rdata));
            check($sformatf("v%0d rvalid", i), NR*DW'(bm.o_rvalid), NR*DW'(vecs[i].e_rvalid));
            check($sformatf("v%0d err", i),    NR*DW'(bm.o_err), NR*DW'(vecs[i].e_err));
            check($sformatf("v%0d dirty", i),  NR*DW'(bm.o_dirty), NR*DW'(vecs[i].e_dirty));
            check($sformatf("v%0d cdone", i),  NR*DW'(bm.o_commit_done), NR*DW'(vecs[i].e_cd));
            check($sformatf("v%0d buf[%0d]", i, vecs[i].chk),
                  NR*DW'(bm.buffer[vecs[i].chk*DW +: DW]), NR*DW'(vecs[i].e_buf));
            check($sformatf("v%0d imm buf[%0d]", i, vecs[i].chk),
                  NR*DW'(bi.buffer[vecs[i].chk*DW +: DW]), NR*DW'(vecs[i].e_ibuf));
            check($sformatf("v%0d imm dirty", i), NR*DW'(bi.o_dirty), '0);
            check($sformatf("v%0d imm cdone", i), NR*DW'(bi.o_commit_done), NR*DW'(vecs[i].e_cd));
        end

        // Fill all 32 addresses, commit, and compare the whole active buffer.
        for (int i = 0; i < 32; i++) begin
            logic [DW-1:0] v;
            v = DW'($urandom_range(0, 15));
            @(negedge clk);
            idle_inputs();
            bm.i_VIC_we = 1'b1; bm.i_VIC_regaddr = AW'(i); bm.i_VIC_data = v;
            if (i < int'(NR) && !ROM[i % NR]) model[i] = v;
        end
        model[1] = 4'h5;
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        check("fill dirty", NR*DW'(bm.o_dirty), NR*DW'(1'b1));
        for (int i = 0; i < int'(NR); i++) exp_flat[i*DW +: DW] = model[i];
        check("fill imm buffer", bi.buffer, exp_flat);
        @(negedge clk);
        bm.i_commit = 1'b1;
        @(posedge clk);
        #1;
        check("fill commit buffer", bm.buffer, exp_flat);
        check("fill commit dirty", NR*DW'(bm.o_dirty), '0);
        check("fill commit cdone", NR*DW'(bm.o_commit_done), NR*DW'(1'b1));

        // Mid-cycle asynchronous reset with every flag raised.
        @(negedge clk);
        bm.i_commit = 1'b1; bm.i_VIC_re = 1'b1; bm.i_VIC_we = 1'b1;
        bm.i_VIC_regaddr = AW'(30); bm.i_VIC_data = 4'h6;
        @(posedge clk);
        #1;
        check("pre-rst rvalid", NR*DW'(bm.o_rvalid), NR*DW'(1'b1));
        check("pre-rst err",    NR*DW'(bm.o_err), NR*DW'(1'b1));
        check("pre-rst cdone",  NR*DW'(bm.o_commit_done), NR*DW'(1'b1));
        #1;
        rst_n = 1'b0;
        #1;
        check("arst rdata",  NR*DW'(bm.o_VIC_data), '0);
        check("arst rvalid", NR*DW'(bm.o_rvalid), '0);
        check("arst err",    NR*DW'(bm.o_err), '0);
        check("arst dirty",  NR*DW'(bm.o_dirty), '0);
        check("arst cdone",  NR*DW'(bm.o_commit_done), '0);
        check("arst buffer", bm.buffer, '0);
        check("arst imm buffer", bi.buffer, '0);
        check("arst imm cdone",  NR*DW'(bi.o_commit_done), '0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-rst buf[3]", NR*DW'(bm.buffer[3*DW +: DW]), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
